// File: rtl/gcd_pkg.sv
// Shared definitions for the Euclid GCD sequencer: state encoding and default width.
package gcd_pkg;

  localparam int unsigned GCD_WIDTH = 32;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_CHECK = 3'd1;
  localparam state_t S_ISSUE = 3'd2;
  localparam state_t S_WAIT  = 3'd3;
  localparam state_t S_SWAP  = 3'd4;
  localparam state_t S_DONE  = 3'd5;

endpackage

// File: rtl/gcd_watchdog.sv
// Per-job watchdog: counts cycles spent waiting on the modulo unit and flags the limit.
module gcd_watchdog #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk,
  input  logic rst_ni,
  input  logic run,
  output logic expired
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  // Held at zero outside WAIT so every job starts from a fresh count.
  always_ff @(posedge clk) begin
    if (!rst_ni || !run) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = run && (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/euclid_gcd_sequencer.sv
// Euclid GCD iteration sequencer driving an external modulo unit (A mod B) until B==0.
// Optional per-job timeout is enabled with the GCD_TIMEOUT_EN macro.
module euclid_gcd_sequencer
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH          = GCD_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] gcd_o,
  output logic             err_o,
  output logic             mod_start_o,
  output logic [WIDTH-1:0] mod_a_o,
  output logic [WIDTH-1:0] mod_b_o,
  input  logic             mod_valid_i,
  input  logic [WIDTH-1:0] mod_rem_i
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, rem_q, gcd_q;
  logic             err_q;
  logic             timeout_hit;

  if (TIMEOUT_CYCLES == 0) begin : g_param_check
    $error("TIMEOUT_CYCLES must be nonzero");
  end

`ifdef GCD_TIMEOUT_EN
  gcd_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst_ni  (rst_ni),
    .run     (state_q == S_WAIT),
    .expired (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A valid arriving on the limit cycle takes priority over the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_CHECK;
      S_CHECK: state_d = (b_q == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (mod_valid_i)      state_d = S_SWAP;
        else if (timeout_hit) state_d = S_DONE;
      end
      S_SWAP:  state_d = S_CHECK;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o      = (state_q != S_IDLE);
    done_o      = (state_q == S_DONE);
    mod_start_o = (state_q == S_ISSUE);
  end

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      a_q   <= '0;
      b_q   <= '0;
      rem_q <= '0;
      gcd_q <= '0;
      err_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            a_q   <= a_i;
            b_q   <= b_i;
            err_q <= 1'b0;
          end
        end
        S_CHECK: begin
          if (b_q == '0) begin
            gcd_q <= a_q;
            if (a_q == '0) err_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (mod_valid_i) begin
            rem_q <= mod_rem_i;
          end else if (timeout_hit) begin
            gcd_q <= '0;
            err_q <= 1'b1;
          end
        end
        S_SWAP: begin
          a_q <= b_q;
          b_q <= rem_q;
        end
        default: ;
      endcase
    end
  end

  assign gcd_o   = gcd_q;
  assign err_o   = err_q;
  assign mod_a_o = a_q;
  assign mod_b_o = b_q;

endmodule
